cb_writeback_arbiter: RTL and testbench

Shares the single completion-buffer result-write port among NUM_REQ functional units (ALU, MUL, DIV, LSU by default). Uses round-robin arbitration. A head-urgency override grants first any result whose entry index equals the current buffer head, so commit is never starved. Sits between the functional-unit result outputs and the completion buffer result inputs, and drives them through one registered output stage with backpressure.

---
 rtl/cb_writeback_arbiter_pkg.sv | 23 ++
 rtl/rr_priority_picker.sv | 31 +++
 rtl/cb_writeback_arbiter.sv | 126 ++++++++++++
 tb/tb_cb_writeback_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_writeback_arbiter_pkg.sv
// Shared types and requester ids for the completion-buffer writeback arbiter.
// The request struct widths must match the IDX_W / DATA_W the top is built with.
package cb_writeback_arbiter_pkg;

    localparam int CB_IDX_W  = 4;
    localparam int CB_DATA_W = 32;
    localparam int CB_VD_W   = 5;
    localparam int URG_CNT_W = 16;

    localparam int REQ_ALU = 0;
    localparam int REQ_MUL = 1;
    localparam int REQ_DIV = 2;
    localparam int REQ_LSU = 3;

    typedef struct packed {
        logic [CB_IDX_W-1:0]  index;
        logic [CB_DATA_W-1:0] data;
        logic [CB_VD_W-1:0]   vd;
        logic                 exception;
        logic                 mal;
    } cb_wb_req_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after start_ptr,
// wrapping modulo NUM_REQ, returned both one-hot and as an id.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   start_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_id,
    output logic               grant_any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start_ptr) + k) % NUM_REQ;
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cb_writeback_arbiter.sv
// Arbitrates functional-unit results onto the single completion-buffer write
// port: head-urgency override first, round-robin otherwise, one output register.
module cb_writeback_arbiter
    import cb_writeback_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = CB_IDX_W,
    parameter int DATA_W  = CB_DATA_W,
    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush,
    input  logic [IDX_W-1:0]      head_index,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*IDX_W-1:0]  req_index,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*5-1:0]  req_vd,
    input  logic [NUM_REQ-1:0]    req_exception,
    input  logic [NUM_REQ-1:0]    req_mal,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [IDX_W-1:0]      wb_index,
    output logic [DATA_W-1:0]     wb_data,
    output logic [4:0]            wb_vd,
    output logic                  wb_exception,
    output logic                  wb_mal,
    output logic [SRC_W-1:0]      wb_src,
    output logic [15:0]           urgent_grants
);

    cb_wb_req_t         req_s [NUM_REQ];
    cb_wb_req_t         wb_q;
    cb_wb_req_t         sel;
    logic [NUM_REQ-1:0] urgent;
    logic [NUM_REQ-1:0] urg_onehot;
    logic               urg_any;
    logic [SRC_W-1:0]   urg_id;
    logic [NUM_REQ-1:0] rr_grant;
    logic [SRC_W-1:0]   rr_id;
    logic               rr_any;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   next_ptr;
    logic [SRC_W-1:0]   grant_id;
    logic               grant_en;
    logic               grant_any;
    logic               slot_free;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_s[i]           = '0;
            req_s[i].index     = req_index[i*IDX_W +: IDX_W];
            req_s[i].data      = req_data[i*DATA_W +: DATA_W];
            req_s[i].vd        = req_vd[i*5 +: 5];
            req_s[i].exception = req_exception[i];
            req_s[i].mal       = req_mal[i];
        end
    end

    // Descending scan so the lowest-numbered urgent unit wins a protocol error.
    always_comb begin
        urgent     = '0;
        urg_onehot = '0;
        urg_any    = 1'b0;
        urg_id     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            urgent[i] = req_valid[i] && (req_s[i].index == head_index);
            if (urgent[i]) begin
                urg_any    = 1'b1;
                urg_id     = SRC_W'(i);
                urg_onehot = '0;
                urg_onehot[i] = 1'b1;
            end
        end
    end

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req       (req_valid),
        .start_ptr (rr_ptr),
        .grant     (rr_grant),
        .grant_id  (rr_id),
        .grant_any (rr_any)
    );

    assign slot_free = ~wb_valid | wb_ready;
    assign grant_en  = ~flush & slot_free;
    assign grant_any = grant_en & (urg_any | rr_any);
    assign grant_id  = urg_any ? urg_id : rr_id;
    assign req_ready = grant_any ? (urg_any ? urg_onehot : rr_grant) : '0;
    assign sel       = req_s[grant_id];
    assign next_ptr  = (grant_id == SRC_W'(NUM_REQ - 1)) ? '0 : grant_id + SRC_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_valid      <= 1'b0;
            wb_q          <= '0;
            wb_src        <= '0;
            rr_ptr        <= '0;
            urgent_grants <= '0;
        end else begin
            if (flush) begin
                wb_valid <= 1'b0;
                rr_ptr   <= '0;
            end else if (grant_any) begin
                wb_valid <= 1'b1;
                wb_q     <= sel;
                wb_src   <= grant_id;
                if (!urg_any) rr_ptr <= next_ptr;
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
            if (grant_any && urg_any && (urgent_grants != 16'hFFFF))
                urgent_grants <= urgent_grants + 16'd1;
        end
    end

    assign wb_index     = wb_q.index;
    assign wb_data      = wb_q.data;
    assign wb_vd        = wb_q.vd;
    assign wb_exception = wb_q.exception;
    assign wb_mal       = wb_q.mal;

endmodule

// File: tb/tb_cb_writeback_arbiter.sv
// Directed bench for cb_writeback_arbiter: inputs change on the falling edge,
// grants are sampled 1ns later and registered outputs 1ns after the rising edge.
module tb_cb_writeback_arbiter;

    logic        CLK;
    logic        RST;
    logic        flush;
    logic [3:0]  head_index;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_index;
    logic [127:0] req_data;
    logic [19:0] req_vd;
    logic [3:0]  req_exception;
    logic [3:0]  req_mal;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_index;
    logic [31:0] wb_data;
    logic [4:0]  wb_vd;
    logic        wb_exception;
    logic        wb_mal;
    logic [1:0]  wb_src;
    logic [15:0] urgent_grants;

    logic [3:0]  t_idx [4];
    logic [31:0] t_data [4];
    logic [4:0]  t_vd [4];

    int vectors;
    int miscompares;

    cb_writeback_arbiter dut (
        .CLK           (CLK),
        .RST           (RST),
        .flush         (flush),
        .head_index    (head_index),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_index     (req_index),
        .req_data      (req_data),
        .req_vd        (req_vd),
        .req_exception (req_exception),
        .req_mal       (req_mal),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_index      (wb_index),
        .wb_data       (wb_data),
        .wb_vd         (wb_vd),
        .wb_exception  (wb_exception),
        .wb_mal        (wb_mal),
        .wb_src        (wb_src),
        .urgent_grants (urgent_grants)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        req_index = '0;
        req_data  = '0;
        req_vd    = '0;
        for (int i = 0; i < 4; i++) begin
            req_index[i*4 +: 4]   = t_idx[i];
            req_data[i*32 +: 32]  = t_data[i];
            req_vd[i*5 +: 5]      = t_vd[i];
        end
    end

    task automatic flush_cycle();
        @(negedge CLK);
        req_valid = 4'b0000;
        flush     = 1'b1;
        @(negedge CLK);
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; flush = 1'b0; head_index = 4'd15; req_valid = '0;
        req_exception = '0; req_mal = '0; wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t_idx[i]  = 4'(i);
            t_data[i] = 32'hA000_0000 + 32'(i);
            t_vd[i]   = 5'(i + 1);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        vectors++;
        if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        vectors++;
        if ({wb_index, wb_data, wb_vd, wb_exception, wb_mal, wb_src} !== '0) begin
            miscompares++; $display("FAIL reset_wb_fields got idx %h data %h src %h want 0", wb_index, wb_data, wb_src);
        end
        vectors++;
        if (urgent_grants !== 16'd0) begin miscompares++; $display("FAIL reset_urgent got %0d want 0", urgent_grants); end
        vectors++;
        if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    endtask

    task automatic test_single();
        @(negedge CLK);
        t_idx[1] = 4'd3; t_data[1] = 32'hDEAD_BEEF; t_vd[1] = 5'd7; req_exception = 4'b0010;
        req_valid = 4'b0010; wb_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL single_ready got %b want 0010", req_ready); end
        @(posedge CLK); #1;
        vectors++;
        if (wb_valid !== 1'b1 || wb_index !== 4'd3 || wb_data !== 32'hDEAD_BEEF || wb_src !== 2'd1
            || wb_vd !== 5'd7 || wb_exception !== 1'b1 || wb_mal !== 1'b0) begin
            miscompares++;
            $display("FAIL single_wb got v%b idx %0d data %h src %0d vd %0d exc %b want v1 idx 3 data deadbeef src 1 vd 7 exc 1",
                     wb_valid, wb_index, wb_data, wb_src, wb_vd, wb_exception);
        end
        @(negedge CLK);
        req_valid = 4'b0000; req_exception = 4'b0000;
        @(posedge CLK); #1;
        vectors++;
        if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b want 0", wb_valid); end
    endtask

    task automatic test_round_robin();
        flush_cycle();
        for (int i = 0; i < 4; i++) begin
            t_idx[i] = 4'(i); t_data[i] = 32'hC0DE_0000 + 32'(i);
        end
        req_valid = 4'b1111; wb_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            vectors++;
            if (req_ready !== (4'b0001 << (k % 4))) begin
                miscompares++; $display("FAIL rr_ready step %0d got %b want %b", k, req_ready, 4'b0001 << (k % 4));
            end
            @(posedge CLK); #1;
            vectors++;
            if (wb_valid !== 1'b1 || wb_src !== 2'(k % 4) || wb_data !== 32'hC0DE_0000 + 32'(k % 4)) begin
                miscompares++; $display("FAIL rr_wb step %0d got v%b src %0d data %h want src %0d", k, wb_valid, wb_src, wb_data, k % 4);
            end
            @(negedge CLK);
        end
        req_valid = 4'b0000;
        @(negedge CLK);
    endtask

    task automatic test_urgency();
        flush_cycle();
        head_index = 4'd5; t_idx[0] = 4'd1; t_idx[2] = 4'd5; t_idx[3] = 4'd9;
        req_valid = 4'b0101; wb_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL urg_ready got %b want 0100", req_ready); end
        @(posedge CLK); #1;
        vectors++;
        if (wb_src !== 2'd2 || urgent_grants !== 16'd1) begin
            miscompares++; $display("FAIL urg_wb got src %0d cnt %0d want src 2 cnt 1", wb_src, urgent_grants);
        end
        @(negedge CLK);
        req_valid = 4'b1001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL urg_ptr_kept got %b want 0001", req_ready); end
        @(posedge CLK); #1;
        vectors++;
        if (wb_src !== 2'd0 || urgent_grants !== 16'd1) begin
            miscompares++; $display("FAIL urg_follow got src %0d cnt %0d want src 0 cnt 1", wb_src, urgent_grants);
        end
        @(negedge CLK);
        req_valid = 4'b1000;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL urg_tail got %b want 1000", req_ready); end
        @(negedge CLK);
        req_valid = 4'b0000; head_index = 4'd15;
        @(negedge CLK);
    endtask

    task automatic test_backpressure();
        t_data[0] = 32'h1111_0000; t_data[3] = 32'h3333_0000;
        req_valid = 4'b0001; wb_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL bp_load got %b want 0001", req_ready); end
        @(negedge CLK);
        req_valid = 4'b1000; wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_ready cycle %0d got %b want 0000", k, req_ready); end
            @(posedge CLK); #1;
            vectors++;
            if (wb_valid !== 1'b1 || wb_src !== 2'd0 || wb_data !== 32'h1111_0000) begin
                miscompares++; $display("FAIL bp_hold cycle %0d got v%b src %0d data %h want v1 src 0 data 11110000", k, wb_valid, wb_src, wb_data);
            end
            @(negedge CLK);
        end
        wb_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_release got %b want 1000", req_ready); end
        @(posedge CLK); #1;
        vectors++;
        if (wb_src !== 2'd3 || wb_data !== 32'h3333_0000) begin
            miscompares++; $display("FAIL bp_next got src %0d data %h want src 3 data 33330000", wb_src, wb_data);
        end
        @(negedge CLK);
        req_valid = 4'b0000;
        @(negedge CLK);
    endtask

    task automatic test_flush();
        req_valid = 4'b0010; wb_ready = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if (wb_valid !== 1'b1 || wb_src !== 2'd1) begin
            miscompares++; $display("FAIL flush_setup got v%b src %0d want v1 src 1", wb_valid, wb_src);
        end
        @(negedge CLK);
        req_valid = 4'b1001; wb_ready = 1'b0; flush = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL flush_no_grant got %b want 0000", req_ready); end
        @(posedge CLK); #1;
        vectors++;
        if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drop got %b want 0", wb_valid); end
        @(negedge CLK);
        flush = 1'b0; wb_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL flush_ptr got %b want 0001", req_ready); end
        @(negedge CLK);
        req_valid = 4'b0000;
        @(negedge CLK);
    endtask

    task automatic test_sync_reset();
        req_valid = 4'b1000; wb_ready = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if (wb_valid !== 1'b1 || wb_src !== 2'd3) begin
            miscompares++; $display("FAIL srst_setup got v%b src %0d want v1 src 3", wb_valid, wb_src);
        end
        @(negedge CLK);
        req_valid = 4'b0000; wb_ready = 1'b0; RST = 1'b1;
        #1;
        vectors++;
        if (wb_valid !== 1'b1 || wb_src !== 2'd3 || urgent_grants !== 16'd1) begin
            miscompares++; $display("FAIL srst_before_edge got v%b src %0d cnt %0d want v1 src 3 cnt 1", wb_valid, wb_src, urgent_grants);
        end
        @(posedge CLK); #1;
        vectors++;
        if (wb_valid !== 1'b0 || {wb_index, wb_data, wb_vd, wb_exception, wb_mal, wb_src} !== '0 || urgent_grants !== 16'd0) begin
            miscompares++; $display("FAIL srst_after_edge got v%b src %0d data %h cnt %0d want all 0", wb_valid, wb_src, wb_data, urgent_grants);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_urgency();
        test_backpressure();
        test_flush();
        test_sync_reset();
        repeat (2) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
